obuf_rd_arb: RTL and testbench

OBUF_RD_ARB -- requirements
Module: obuf_rd_arb

---
 rtl/obuf_rd_arb_pkg.sv | 23 ++
 rtl/obuf_rd_arb_bank_arb.sv | 100 ++++++++++
 rtl/obuf_rd_arb.sv | 65 ++++++
 tb/tb_obuf_rd_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_rd_arb_pkg.sv
// Common: shared OBuffer geometry and the requester identifier used by the
// OBuffer read arbiter.
//   OBufBank  : number of independently arbitrated read banks
//   OBufDepth : words per bank (address width is $clog2 of this)
//   OBufWidth : read data bits per bank
//   ArbSide   : which requester a grant or return belongs to (VCtrl / ECtrl)
package Common;

  localparam int OBufBank  = 4;
  localparam int OBufDepth = 16;
  localparam int OBufWidth = 8;

  typedef enum logic {
    ARB_V = 1'b0,
    ARB_E = 1'b1
  } ArbSide;

  // The side that did not win, used to hand priority to the loser
  function automatic ArbSide otherSide(input ArbSide s);
    return (s == ARB_V) ? ARB_E : ARB_V;
  endfunction

endpackage

// File: rtl/obuf_rd_arb_bank_arb.sv
// obuf_bank_arb: two-requester arbiter for a single OBuffer bank plus the
// return pipe that steers read-valid back to whichever side was granted.
//   clk, rst         : clock, synchronous active-high reset
//   vReq/vAddr/vLock : VCtrl request, address and burst lock
//   eReq/eAddr/eLock : ECtrl request, address and burst lock
//   vGnt/eGnt        : combinational grants for this cycle
//   rEn/rAddr        : bank read strobe and address (0 when idle)
//   vRValid/eRValid  : read-data valid, RdLat cycles after the grant
module obuf_bank_arb
  import Common::*;
#(
  parameter int AW    = 4,
  parameter int RdLat = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vReq,
  input  logic [AW-1:0] vAddr,
  input  logic          vLock,
  input  logic          eReq,
  input  logic [AW-1:0] eAddr,
  input  logic          eLock,
  output logic          vGnt,
  output logic          eGnt,
  output logic          rEn,
  output logic [AW-1:0] rAddr,
  output logic          vRValid,
  output logic          eRValid
);

  ArbSide           r_pri;
  logic             r_ownerValid;
  ArbSide           r_ownerSide;
  logic [RdLat-1:0] r_pipeValid;
  ArbSide           r_pipeSide [RdLat];

  logic w_lockHeld;
  logic w_vGnt;
  logic w_eGnt;

  // A latched owner keeps the bank only while it still requests with its
  // lock high; otherwise ownership lapses and normal arbitration applies in
  // the same cycle. Reset suppresses every grant.
  always_comb begin
    w_lockHeld = 1'b0;
    w_vGnt     = 1'b0;
    w_eGnt     = 1'b0;
    if (r_ownerValid) begin
      w_lockHeld = (r_ownerSide == ARB_V) ? (vLock && vReq) : (eLock && eReq);
    end
    if (!rst) begin
      if (w_lockHeld) begin
        w_vGnt = (r_ownerSide == ARB_V);
        w_eGnt = (r_ownerSide == ARB_E);
      end else if (vReq && eReq) begin
        w_vGnt = (r_pri == ARB_V);
        w_eGnt = (r_pri == ARB_E);
      end else begin
        w_vGnt = vReq;
        w_eGnt = eReq;
      end
    end
  end

  assign vGnt  = w_vGnt;
  assign eGnt  = w_eGnt;
  assign rEn   = w_vGnt | w_eGnt;
  assign rAddr = w_eGnt ? eAddr : (w_vGnt ? vAddr : '0);

  // Priority moves to the loser after every contested grant; ownership is
  // re-evaluated each cycle from the winner's lock, so a held lock simply
  // re-latches. The return pipe records {valid, side} for every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pri        <= ARB_V;
      r_ownerValid <= 1'b0;
      r_ownerSide  <= ARB_V;
      r_pipeValid  <= '0;
      for (int i = 0; i < RdLat; i++) begin
        r_pipeSide[i] <= ARB_V;
      end
    end else begin
      if (vReq && eReq && (w_vGnt || w_eGnt)) begin
        r_pri <= otherSide(w_eGnt ? ARB_E : ARB_V);
      end
      r_ownerValid   <= (w_vGnt && vLock) || (w_eGnt && eLock);
      r_ownerSide    <= w_eGnt ? ARB_E : ARB_V;
      r_pipeValid[0] <= w_vGnt | w_eGnt;
      r_pipeSide[0]  <= w_eGnt ? ARB_E : ARB_V;
      for (int i = 1; i < RdLat; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeSide[i]  <= r_pipeSide[i-1];
      end
    end
  end

  assign vRValid = r_pipeValid[RdLat-1] && (r_pipeSide[RdLat-1] == ARB_V);
  assign eRValid = r_pipeValid[RdLat-1] && (r_pipeSide[RdLat-1] == ARB_E);

endmodule

// File: rtl/obuf_rd_arb.sv
// obuf_rd_arb: OBuffer read arbiter between VCtrl and ECtrl. Every bank is
// arbitrated on its own by an obuf_bank_arb; read data is fanned out to both
// requesters unconditionally and only the valid bits are steered.
//   clk, rst                 : clock, synchronous active-high reset
//   vReq/vAddr/vLock         : VCtrl per-bank requests, addresses, burst lock
//   eReq/eAddr/eLock         : ECtrl per-bank requests, addresses, burst lock
//   vGnt/eGnt                : per-bank grants, same cycle as the request
//   rEn/rAddr                : OBuffer bank read enables and addresses
//   rData                    : OBuffer read data, RdLat cycles after rEn
//   vRValid/eRValid          : per-bank return valid to the granted side
//   vRData/eRData            : read data fanout
module obuf_rd_arb #(
  parameter int OBufBank  = Common::OBufBank,
  parameter int OBufDepth = Common::OBufDepth,
  parameter int OBufWidth = Common::OBufWidth,
  parameter int RdLat     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [OBufBank-1:0]                   vReq,
  input  logic [OBufBank*$clog2(OBufDepth)-1:0] vAddr,
  input  logic                                  vLock,
  input  logic [OBufBank-1:0]                   eReq,
  input  logic [OBufBank*$clog2(OBufDepth)-1:0] eAddr,
  input  logic                                  eLock,
  output logic [OBufBank-1:0]                   vGnt,
  output logic [OBufBank-1:0]                   eGnt,
  output logic [OBufBank-1:0]                   rEn,
  output logic [OBufBank*$clog2(OBufDepth)-1:0] rAddr,
  input  logic [OBufBank*OBufWidth-1:0]         rData,
  output logic [OBufBank-1:0]                   vRValid,
  output logic [OBufBank-1:0]                   eRValid,
  output logic [OBufBank*OBufWidth-1:0]         vRData,
  output logic [OBufBank*OBufWidth-1:0]         eRData
);

  localparam int AW = $clog2(OBufDepth);

  // One arbiter and return pipe per bank; banks share only the lock inputs
  for (genvar b = 0; b < OBufBank; b++) begin : g_bank
    obuf_bank_arb #(
      .AW    (AW),
      .RdLat (RdLat)
    ) u_bankArb (
      .clk     (clk),
      .rst     (rst),
      .vReq    (vReq[b]),
      .vAddr   (vAddr[b*AW +: AW]),
      .vLock   (vLock),
      .eReq    (eReq[b]),
      .eAddr   (eAddr[b*AW +: AW]),
      .eLock   (eLock),
      .vGnt    (vGnt[b]),
      .eGnt    (eGnt[b]),
      .rEn     (rEn[b]),
      .rAddr   (rAddr[b*AW +: AW]),
      .vRValid (vRValid[b]),
      .eRValid (eRValid[b])
    );
  end

  assign vRData = rData;
  assign eRData = rData;

endmodule

// File: tb/tb_obuf_rd_arb.sv
// tb_obuf_rd_arb: directed scenarios with literal expectations, then long
// randomized V/E traffic, all compared every cycle against a queue-based
// behavioural model of the arbiter.
module tb_obuf_rd_arb;

  localparam int NB    = Common::OBufBank;
  localparam int DEPTH = Common::OBufDepth;
  localparam int W     = Common::OBufWidth;
  localparam int AW    = $clog2(DEPTH);
  localparam int RDLAT = 3;
  localparam int NRAND = 10000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   vReq, eReq;
  logic [NB*AW-1:0] vAddr, eAddr;
  logic            vLock, eLock;
  logic [NB-1:0]   vGnt, eGnt, rEn;
  logic [NB*AW-1:0] rAddr;
  logic [NB*W-1:0] rData;
  logic [NB-1:0]   vRValid, eRValid;
  logic [NB*W-1:0] vRData, eRData;

  int checks = 0;
  int errors = 0;

  obuf_rd_arb #(
    .OBufBank  (NB),
    .OBufDepth (DEPTH),
    .OBufWidth (W),
    .RdLat     (RDLAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .vReq    (vReq),
    .vAddr   (vAddr),
    .vLock   (vLock),
    .eReq    (eReq),
    .eAddr   (eAddr),
    .eLock   (eLock),
    .vGnt    (vGnt),
    .eGnt    (eGnt),
    .rEn     (rEn),
    .rAddr   (rAddr),
    .rData   (rData),
    .vRValid (vRValid),
    .eRValid (eRValid),
    .vRData  (vRData),
    .eRData  (eRData)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    vReq  = '0;
    eReq  = '0;
    vAddr = '0;
    eAddr = '0;
    vLock = 1'b0;
    eLock = 1'b0;
  endtask

  // Inputs are already set; refresh read data and move to the sampling edge
  task automatic applyStimulus();
    for (int b = 0; b < NB; b++) rData[b*W +: W] = W'($urandom);
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    applyStimulus();
    nextCycle();
    applyStimulus();
    nextCycle();
    rst = 1'b0;
  endtask

  // Behavioural model: side codes 0 = none, 1 = V, 2 = E. Each bank keeps
  // its priority side, its lock owner and a queue of the last RDLAT grants.
  int  mPri   [NB];
  int  mOwner [NB];
  int  retQ   [NB][$];
  int  waitV  [NB];
  int  waitE  [NB];
  bit  mKnown = 1'b0;

  initial begin
    for (int b = 0; b < NB; b++) begin
      mPri[b]   = 1;
      mOwner[b] = 0;
      waitV[b]  = 0;
      waitE[b]  = 0;
      repeat (RDLAT) retQ[b].push_back(0);
    end
  end

  // Every cycle: derive the expected outputs from the model, compare the
  // whole DUT output set, then advance the model as the clock edge will.
  always @(negedge clk) begin
    logic [NB-1:0]    eVG, eEG, eVV, eEV;
    logic [NB*AW-1:0] eRA;
    int               g;
    bit               lockBranch;
    int               worstWait;
    worstWait = 0;
    for (int b = 0; b < NB; b++) begin
      g = 0;
      lockBranch = 1'b0;
      if (!rst) begin
        if (mOwner[b] == 1 && vLock && vReq[b]) begin
          g = 1; lockBranch = 1'b1;
        end else if (mOwner[b] == 2 && eLock && eReq[b]) begin
          g = 2; lockBranch = 1'b1;
        end else if (vReq[b] && eReq[b]) g = mPri[b];
        else if (vReq[b]) g = 1;
        else if (eReq[b]) g = 2;
      end
      eVG[b] = (g == 1);
      eEG[b] = (g == 2);
      eRA[b*AW +: AW] = (g == 1) ? vAddr[b*AW +: AW] : ((g == 2) ? eAddr[b*AW +: AW] : '0);
      eVV[b] = (retQ[b][0] == 1);
      eEV[b] = (retQ[b][0] == 2);

      // Unlocked waiting time of each side, measured on the DUT's grants
      if (rst || !vReq[b] || vGnt[b]) waitV[b] = 0;
      else if (!lockBranch) waitV[b]++;
      if (rst || !eReq[b] || eGnt[b]) waitE[b] = 0;
      else if (!lockBranch) waitE[b]++;
      if (waitV[b] > worstWait) worstWait = waitV[b];
      if (waitE[b] > worstWait) worstWait = waitE[b];

      if (rst) begin
        mPri[b]   = 1;
        mOwner[b] = 0;
        retQ[b].delete();
        repeat (RDLAT) retQ[b].push_back(0);
      end else begin
        if (vReq[b] && eReq[b] && g != 0) mPri[b] = (g == 1) ? 2 : 1;
        mOwner[b] = (g == 1 && vLock) ? 1 : ((g == 2 && eLock) ? 2 : 0);
        retQ[b].push_back(g);
        void'(retQ[b].pop_front());
      end
    end
    checkOutput("model vGnt", 64'(vGnt), 64'(eVG));
    checkOutput("model eGnt", 64'(eGnt), 64'(eEG));
    checkOutput("model rEn", 64'(rEn), 64'(eVG | eEG));
    checkOutput("model rAddr", 64'(rAddr), 64'(eRA));
    checkOutput("model vRData", 64'(vRData), 64'(rData));
    checkOutput("model eRData", 64'(eRData), 64'(rData));
    if (mKnown) begin
      checkOutput("model vRValid", 64'(vRValid), 64'(eVV));
      checkOutput("model eRValid", 64'(eRValid), 64'(eEV));
    end
    checks++;
    if (worstWait > 2) begin
      errors++;
      $display("[TB] FAIL fairWait actual=%0d required<=2 @%0t", worstWait, $time);
    end
    if (rst) mKnown = 1'b1;
  end

  logic [NB-1:0] lastVG, lastEG;

  initial begin
    rst   = 1'b1;
    rData = '0;
    idleInputs();
    lastVG = '0;
    lastEG = '0;

    // Single V read on bank 0 with address 5
    doReset();
    vReq[0] = 1'b1;
    vAddr[0 +: AW] = AW'(5);
    applyStimulus();
    checkOutput("A vGnt0", 64'(vGnt[0]), 64'(1));
    checkOutput("A rEn0", 64'(rEn[0]), 64'(1));
    checkOutput("A rAddr0", 64'(rAddr[0 +: AW]), 64'(5));
    nextCycle();
    idleInputs();
    for (int k = 1; k <= RDLAT; k++) begin
      applyStimulus();
      checkOutput($sformatf("A vRValid0 c%0d", k), 64'(vRValid[0]), 64'(k == RDLAT));
      nextCycle();
    end

    // Contested bank 1 without lock alternates V,E,V,E
    doReset();
    for (int k = 0; k < 6 + RDLAT; k++) begin
      idleInputs();
      if (k < 6) begin
        vReq[1] = 1'b1;
        eReq[1] = 1'b1;
      end
      applyStimulus();
      if (k < 6) begin
        checkOutput($sformatf("B vGnt1 c%0d", k), 64'(vGnt[1]), 64'(k % 2 == 0));
        checkOutput($sformatf("B eGnt1 c%0d", k), 64'(eGnt[1]), 64'(k % 2 == 1));
      end
      if (k >= RDLAT) begin
        checkOutput($sformatf("B vRValid1 c%0d", k), 64'(vRValid[1]), 64'((k - RDLAT) % 2 == 0));
        checkOutput($sformatf("B eRValid1 c%0d", k), 64'(eRValid[1]), 64'((k - RDLAT) % 2 == 1));
      end
      nextCycle();
    end

    // V locks bank 2 for four cycles; E wins when the lock drops
    doReset();
    for (int k = 0; k < 5; k++) begin
      idleInputs();
      vReq[2] = 1'b1;
      eReq[2] = 1'b1;
      vLock   = (k < 4);
      applyStimulus();
      checkOutput($sformatf("C vGnt2 c%0d", k), 64'(vGnt[2]), 64'(k < 4));
      checkOutput($sformatf("C eGnt2 c%0d", k), 64'(eGnt[2]), 64'(k == 4));
      nextCycle();
    end

    // Independent banks both granted; priority untouched
    doReset();
    vReq[0] = 1'b1;
    eReq[1] = 1'b1;
    applyStimulus();
    checkOutput("D vGnt0", 64'(vGnt[0]), 64'(1));
    checkOutput("D eGnt1", 64'(eGnt[1]), 64'(1));
    nextCycle();
    vReq[1:0] = 2'b11;
    eReq[1:0] = 2'b11;
    applyStimulus();
    checkOutput("D vGnt contested", 64'(vGnt[1:0]), 64'(3));
    nextCycle();

    // Reset with a read in flight drops it and restores V priority
    doReset();
    vReq[0] = 1'b1;
    eReq[0] = 1'b1;
    applyStimulus();
    checkOutput("E vGnt0 pre", 64'(vGnt[0]), 64'(1));
    nextCycle();
    idleInputs();
    applyStimulus();
    nextCycle();
    rst = 1'b1;
    applyStimulus();
    nextCycle();
    rst = 1'b0;
    vReq[0] = 1'b1;
    eReq[0] = 1'b1;
    applyStimulus();
    checkOutput("E vGnt0 post", 64'(vGnt[0]), 64'(1));
    checkOutput("E vRValid0 c0", 64'(vRValid[0]), 64'(0));
    checkOutput("E eRValid0 c0", 64'(eRValid[0]), 64'(0));
    nextCycle();
    idleInputs();
    for (int k = 1; k < RDLAT; k++) begin
      applyStimulus();
      checkOutput($sformatf("E vRValid0 c%0d", k), 64'(vRValid[0]), 64'(0));
      nextCycle();
    end

    // Random traffic; an ungranted requester holds its request and address
    lastVG = '0;
    lastEG = '0;
    for (int c = 0; c < NRAND; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < NB; b++) begin
        if (!(vReq[b] && !lastVG[b])) begin
          vReq[b] = 1'($urandom_range(0, 1));
          vAddr[b*AW +: AW] = AW'($urandom);
        end
        if (!(eReq[b] && !lastEG[b])) begin
          eReq[b] = 1'($urandom_range(0, 1));
          eAddr[b*AW +: AW] = AW'($urandom);
        end
      end
      vLock = ($urandom_range(0, 3) == 0);
      eLock = ($urandom_range(0, 3) == 0);
      applyStimulus();
      lastVG = vGnt;
      lastEG = eGnt;
      nextCycle();
    end

    rst = 1'b0;
    idleInputs();
    applyStimulus();
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
